// File: rtl/run_controller_if.sv
// Bus between the processor bench/top level and the run controller.
// Carries the start request, the snooped processor PC and data-memory write
// port, and the controller's status/result outputs.
//
// Handshake: start is a single-cycle request with no ready/acknowledge. The
// controller accepts it only in IDLE or DONE (it is sampled on the rising
// edge of clk) and silently drops it in RST_HOLD and RUN. The snoop signals
// carry no handshake at all: they are sampled every RUN cycle.
interface run_controller_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);

  // Requester side: run request and snooped processor activity.
  logic                  start;
  logic [ADDR_WIDTH-1:0] cpu_pc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [ADDR_WIDTH-1:0] mem_wdata;

  // Controller side: processor reset, run state and results.
  logic                  cpu_reset;
  logic                  running;
  logic                  done;
  logic [1:0]            status;
  logic [ADDR_WIDTH-1:0] exit_code;
  logic [CNT_WIDTH-1:0]  cycle_count;
  logic [1:0]            state_dbg;

  // Bench or top level that starts runs and watches the results.
  modport master (
    output start,
    output cpu_pc,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  cpu_reset,
    input  running,
    input  done,
    input  status,
    input  exit_code,
    input  cycle_count,
    input  state_dbg
  );

  // The run controller itself.
  modport slave (
    input  start,
    input  cpu_pc,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output cpu_reset,
    output running,
    output done,
    output status,
    output exit_code,
    output cycle_count,
    output state_dbg
  );

endinterface

// File: rtl/run_controller.sv
// Run controller for the single-cycle processor.
// Holds the core in reset for RESET_CYCLES cycles after a start request,
// lets it run, and stops it on a halt-address write, a PC self-loop or a
// cycle-budget timeout. Reports the stop cause, the exit value and the
// number of RUN cycles executed. Every output is a flop.
module run_controller #(
  parameter int                    RESET_CYCLES = 2,
  parameter int                    MAX_CYCLES   = 2500,
  parameter int                    STALL_LIMIT  = 8,
  parameter int                    CNT_WIDTH    = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR    = ADDR_WIDTH'(32'hFFFF_FFFC)
) (
  input  logic               clk,
  input  logic               reset,
  run_controller_if.slave    bus
);

  // Hold counter counts RESET_CYCLES-1 down to 0; it needs at least one bit.
  localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  // Match counter counts equal-PC comparisons up to STALL_LIMIT-1.
  localparam int MATCH_W = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;

  localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [MATCH_W-1:0]   MATCH_MAX = MATCH_W'(STALL_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_CYCLES);

  // Stop-cause encoding on the status output.
  localparam logic [1:0] ST_NONE    = 2'd0;
  localparam logic [1:0] ST_HALT    = 2'd1;
  localparam logic [1:0] ST_LOOP    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RST_HOLD = 2'd1,
    S_RUN      = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [HOLD_W-1:0]     hold_q,     hold_d;
  logic [MATCH_W-1:0]    match_q,    match_d;
  logic [ADDR_WIDTH-1:0] prev_pc_q,  prev_pc_d;
  logic                  pc_valid_q, pc_valid_d;
  logic [CNT_WIDTH-1:0]  count_q,    count_d;
  logic [1:0]            status_q,   status_d;
  logic [ADDR_WIDTH-1:0] exit_q,     exit_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  running_q,   running_d;
  logic                  done_q,      done_d;

  // Stop detection for the current RUN cycle.
  logic [CNT_WIDTH-1:0]  count_inc;
  logic                  pc_same;
  logic [MATCH_W-1:0]    match_next;
  logic                  halt_hit;
  logic                  loop_hit;
  logic                  timeout_hit;
  logic                  stop_hit;

  // Post-increment cycle count, which is what the timeout compares against.
  assign count_inc = count_q + CNT_WIDTH'(1);

  // The first RUN cycle only records the PC; comparisons start on the second.
  assign pc_same = pc_valid_q && (bus.cpu_pc == prev_pc_q);

  // Equal-PC comparisons in a row, saturating at the self-loop threshold.
  assign match_next = !pc_same              ? '0 :
                      (match_q == MATCH_MAX) ? match_q :
                                               match_q + MATCH_W'(1);

  assign halt_hit    = bus.mem_we && (bus.mem_addr == HALT_ADDR);
  assign loop_hit    = (match_next == MATCH_MAX);
  assign timeout_hit = (count_inc == CNT_MAX);
  assign stop_hit    = halt_hit || loop_hit || timeout_hit;

  // State register; reset aborts any run straight back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is only honoured in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.start) state_d = S_RST_HOLD;
      S_RST_HOLD: if (hold_q == '0) state_d = S_RUN;
      S_RUN:      if (stop_hit) state_d = S_DONE;
      S_DONE:     if (bus.start) state_d = S_RST_HOLD;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values, including the decoded output flags.
  always_comb begin
    hold_d     = hold_q;
    match_d    = match_q;
    prev_pc_d  = prev_pc_q;
    pc_valid_d = pc_valid_q;
    count_d    = count_q;
    status_d   = status_q;
    exit_d     = exit_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A new run starts with cleared results and a fresh hold count.
        if (bus.start) begin
          hold_d     = HOLD_LOAD;
          match_d    = '0;
          pc_valid_d = 1'b0;
          count_d    = '0;
          status_d   = ST_NONE;
          exit_d     = '0;
        end
      end
      S_RST_HOLD: begin
        // Saturating countdown; the state logic leaves on zero.
        if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
      end
      S_RUN: begin
        // The stop cycle itself is counted, so the count always advances.
        count_d    = count_inc;
        prev_pc_d  = bus.cpu_pc;
        pc_valid_d = 1'b1;
        match_d    = match_next;
        // Priority: halt write, then self-loop, then timeout.
        if (halt_hit) begin
          status_d = ST_HALT;
          exit_d   = bus.mem_wdata;
        end else if (loop_hit) begin
          status_d = ST_LOOP;
        end else if (timeout_hit) begin
          status_d = ST_TIMEOUT;
        end
      end
      default: begin
        hold_d = hold_q;
      end
    endcase

    // Flags follow the state being entered so they line up with state_q.
    cpu_reset_d = (state_d != S_RUN);
    running_d   = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
  end

  // Datapath and output registers; the processor is held in reset on abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      match_q     <= '0;
      prev_pc_q   <= '0;
      pc_valid_q  <= 1'b0;
      count_q     <= '0;
      status_q    <= ST_NONE;
      exit_q      <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      match_q     <= match_d;
      prev_pc_q   <= prev_pc_d;
      pc_valid_q  <= pc_valid_d;
      count_q     <= count_d;
      status_q    <= status_d;
      exit_q      <= exit_d;
      cpu_reset_q <= cpu_reset_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.status      = status_q;
  assign bus.exit_code   = exit_q;
  assign bus.cycle_count = count_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller. Two instances share the same stimulus: dut_a has
// the default 2500-cycle budget, dut_b a 5-cycle budget for the timeout and
// halt-beats-timeout boundaries. Run results of dut_a are predicted when the
// stop stimulus is driven and compared when done rises.
module tb_run_controller;

  localparam int AW    = 32;
  localparam int CW    = 32;
  localparam int RC    = 3;
  localparam int MAXA  = 2500;
  localparam int MAXB  = 5;
  localparam int STALL = 8;
  // Observed word: {cpu_reset, running, done, status, exit_code, cycle_count}
  localparam int W     = 3 + 2 + AW + CW;
  localparam logic [AW-1:0] HALT = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic reset;

  int n_vec = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  logic         done_prev = 1'b0;

  run_controller_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus_a ();
  run_controller_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus_b ();

  assign bus_b.start     = bus_a.start;
  assign bus_b.cpu_pc    = bus_a.cpu_pc;
  assign bus_b.mem_we    = bus_a.mem_we;
  assign bus_b.mem_addr  = bus_a.mem_addr;
  assign bus_b.mem_wdata = bus_a.mem_wdata;

  run_controller #(
    .RESET_CYCLES(RC), .MAX_CYCLES(MAXA), .STALL_LIMIT(STALL),
    .CNT_WIDTH(CW), .ADDR_WIDTH(AW), .HALT_ADDR(HALT)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  run_controller #(
    .RESET_CYCLES(RC), .MAX_CYCLES(MAXB), .STALL_LIMIT(STALL),
    .CNT_WIDTH(CW), .ADDR_WIDTH(AW), .HALT_ADDR(HALT)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [2:0] fl, input logic [1:0] st,
                                      input logic [AW-1:0] ex, input logic [CW-1:0] cnt);
    return {fl, st, ex, cnt};
  endfunction

  function automatic logic [W-1:0] obs_a();
    return {bus_a.cpu_reset, bus_a.running, bus_a.done,
            bus_a.status, bus_a.exit_code, bus_a.cycle_count};
  endfunction

  function automatic logic [W-1:0] obs_b();
    return {bus_b.cpu_reset, bus_b.running, bus_b.done,
            bus_b.status, bus_b.exit_code, bus_b.cycle_count};
  endfunction

  // Scoreboard: compare each completed run of dut_a with its prediction.
  always @(negedge clk) begin
    if (bus_a.done && !done_prev) begin
      check_eq("sb_pending", W'(exp_q.size() > 0), W'(1));
      if (exp_q.size() > 0) check_eq("run_result", obs_a(), exp_q.pop_front());
    end
    done_prev <= bus_a.done;
  end

  // One RUN cycle of stimulus; returns at the next falling edge.
  task automatic drive_cycle(input logic [AW-1:0] pc, input logic we,
                             input logic [AW-1:0] addr, input logic [AW-1:0] wd,
                             input logic st);
    bus_a.cpu_pc    = pc;
    bus_a.mem_we    = we;
    bus_a.mem_addr  = addr;
    bus_a.mem_wdata = wd;
    bus_a.start     = st;
    @(negedge clk);
  endtask

  // Start pulse plus checks of the reset-hold window; returns in RUN cycle 1.
  task automatic start_run();
    bus_a.start  = 1'b1;
    bus_a.mem_we = 1'b0;
    bus_a.cpu_pc = '0;
    @(negedge clk);
    bus_a.start = 1'b0;
    for (int i = 0; i < RC; i++) begin
      check_eq("hold_window", obs_a(), mk(3'b100, 2'd0, '0, '0));
      @(negedge clk);
    end
    check_eq("run_entry", obs_a(), mk(3'b010, 2'd0, '0, '0));
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!bus_a.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_done", W'(bus_a.done), W'(1));
  endtask

  initial begin
    logic [AW-1:0] wd;
    logic          we;
    logic [AW-1:0] addr;

    reset           = 1'b1;
    bus_a.start     = 1'b0;
    bus_a.cpu_pc    = '0;
    bus_a.mem_we    = 1'b0;
    bus_a.mem_addr  = '0;
    bus_a.mem_wdata = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check_eq("reset_state", obs_a(), mk(3'b100, 2'd0, '0, '0));
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle", obs_a(), mk(3'b100, 2'd0, '0, '0));
    end

    // Halt write on RUN cycle 11
    start_run();
    for (int i = 0; i < 10; i++) drive_cycle(AW'(4 * i), 1'b0, '0, '0, 1'b0);
    exp_q.push_back(mk(3'b101, 2'd1, 32'h0000_002A, 32'd11));
    drive_cycle(32'd40, 1'b1, HALT, 32'h0000_002A, 1'b0);
    wait_done(2);
    check_eq("b_timeout5", obs_b(), mk(3'b101, 2'd3, '0, 32'd5));
    for (int i = 0; i < 3; i++) drive_cycle(AW'(100 + 4 * i), 1'b0, '0, '0, 1'b0);
    check_eq("done_hold", obs_a(), mk(3'b101, 2'd1, 32'h0000_002A, 32'd11));

    // Self-loop: 20 distinct PCs, then park at 0x50 for 8 cycles
    start_run();
    for (int i = 0; i < 20; i++) drive_cycle(AW'(4 * i), 1'b0, '0, '0, 1'b0);
    exp_q.push_back(mk(3'b101, 2'd2, '0, 32'd28));
    for (int i = 0; i < 7; i++) drive_cycle(32'h50, 1'b0, '0, '0, 1'b0);
    check_eq("loop_not_early", W'(bus_a.done), W'(0));
    drive_cycle(32'h50, 1'b0, '0, '0, 1'b0);
    wait_done(2);

    // Timeout: PC held for STALL-1 cycles at a time, stray writes, start ignored
    start_run();
    exp_q.push_back(mk(3'b101, 2'd3, '0, CW'(MAXA)));
    for (int i = 0; i < MAXA; i++) begin
      we   = ($urandom_range(0, 3) == 0);
      addr = $urandom() & 32'hFFFF_FFF0;
      if (i % 50 == 7) begin
        we   = 1'b0;
        addr = HALT;
      end
      drive_cycle(AW'((i / (STALL - 1)) * 4), we, addr, $urandom(), (i == 100));
    end
    wait_done(2);

    // Halt and timeout in the same cycle on dut_b: halt wins
    start_run();
    for (int i = 0; i < 4; i++) drive_cycle(AW'(4 * i), 1'b0, '0, '0, 1'b0);
    wd = $urandom();
    exp_q.push_back(mk(3'b101, 2'd1, wd, 32'd5));
    drive_cycle(32'd16, 1'b1, HALT, wd, 1'b0);
    wait_done(2);
    check_eq("b_halt_beats_timeout", obs_b(), mk(3'b101, 2'd1, wd, 32'd5));

    // Asynchronous reset in the middle of a run
    start_run();
    for (int i = 0; i < 10; i++) drive_cycle(AW'(4 * i), 1'b0, '0, '0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_outputs", obs_a(), mk(3'b100, 2'd0, '0, '0));
    check_eq("abort_state", W'(bus_a.state_dbg), W'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("after_abort", obs_a(), mk(3'b100, 2'd0, '0, '0));

    check_eq("sb_drained", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
